// File: rtl/game_pkg.sv
// Shared game types: coordinate width, bomb slot states and a coordinate distance helper.
package game_pkg;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned FUSE_W  = 8;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } slot_state_t;

    // Absolute difference of two map coordinates, one bit wider so nothing wraps.
    function automatic logic [COORD_W:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
        logic [COORD_W:0] ea;
        logic [COORD_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: holds position and fuse, walks FREE -> ARMED -> PENDING -> FREE.
module bomb_slot
    import game_pkg::*;
#(
    parameter int unsigned FUSE_TICKS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               alloc,
    input  logic               select,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    output slot_state_t        state,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    slot_state_t        state_nxt;
    logic [FUSE_W-1:0]  fuse;
    logic [FUSE_W-1:0]  fuse_nxt;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

    // Next-state: load on alloc, count fuse on tick, release once selected.
    always_comb begin
        state_nxt = state;
        fuse_nxt  = fuse;
        x_nxt     = x;
        y_nxt     = y;
        case (state)
            FREE: begin
                if (alloc) begin
                    state_nxt = ARMED;
                    fuse_nxt  = FUSE_W'(FUSE_TICKS);
                    x_nxt     = load_x;
                    y_nxt     = load_y;
                end
            end
            ARMED: begin
                if (tick) begin
                    fuse_nxt = fuse - FUSE_W'(1);
                    if (fuse == FUSE_W'(1)) begin
                        state_nxt = PENDING;
                    end
                end
            end
            PENDING: begin
                if (select) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= FREE;
            fuse  <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= state_nxt;
            fuse  <= fuse_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
        end
    end

endmodule

// File: rtl/stun_detector.sv
// Bomb tracker and stun generator for one player.
// Optional immunity window after a stun is enabled by defining STUN_IMMUNITY_EN.
module stun_detector
    import game_pkg::*;
#(
    parameter int unsigned NUM_BOMBS    = 4,
    parameter int unsigned FUSE_TICKS   = 8,
    parameter int unsigned STUN_TICKS   = 6,
    parameter int unsigned BLAST_RADIUS = 2
`ifdef STUN_IMMUNITY_EN
    ,
    parameter int unsigned IMMUNE_TICKS = 4
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               bombRequested,
    input  logic [COORD_W-1:0] bombX,
    input  logic [COORD_W-1:0] bombY,
    input  logic [COORD_W-1:0] playerX,
    input  logic [COORD_W-1:0] playerY,
    output logic               bombAccepted,
    output logic               explosionValid,
    output logic [COORD_W-1:0] explosionX,
    output logic [COORD_W-1:0] explosionY,
    output logic [3:0]         activeBombs,
    output logic               stunnedEffect
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ACT_W = 4;
    localparam int unsigned RAD_W = COORD_W + 1;

    slot_state_t                       slot_state [NUM_BOMBS];
    logic [NUM_BOMBS-1:0][COORD_W-1:0] slot_x;
    logic [NUM_BOMBS-1:0][COORD_W-1:0] slot_y;
    logic [COORD_W-1:0][NUM_BOMBS-1:0] xcol;
    logic [COORD_W-1:0][NUM_BOMBS-1:0] ycol;
    logic [NUM_BOMBS-1:0] is_free;
    logic [NUM_BOMBS-1:0] is_pend;
    logic [NUM_BOMBS-1:0] match;
    logic [NUM_BOMBS-1:0] alloc_vec;
    logic [NUM_BOMBS-1:0] sel_vec;
    logic [COORD_W-1:0]   sel_x;
    logic [COORD_W-1:0]   sel_y;
    logic                 accept;
    logic                 pend_found;
    logic                 hit;
    logic                 hit_q;
    logic                 load_ok;
    logic [CNT_W-1:0]     stun_cnt;
    logic [CNT_W-1:0]     stun_nxt;

    // Slot array plus per-slot status and coordinate transposition for the select mux.
    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS(FUSE_TICKS)
        ) u_slot (
            .clock (clock),
            .reset (reset),
            .tick  (tick),
            .alloc (alloc_vec[g] & accept),
            .select(sel_vec[g]),
            .load_x(bombX),
            .load_y(bombY),
            .state (slot_state[g]),
            .x     (slot_x[g]),
            .y     (slot_y[g])
        );
        assign is_free[g] = (slot_state[g] == FREE);
        assign is_pend[g] = (slot_state[g] == PENDING);
        assign match[g]   = !is_free[g] && (slot_x[g] == bombX) && (slot_y[g] == bombY);
        for (genvar b = 0; b < COORD_W; b++) begin : g_bit
            assign xcol[b][g] = slot_x[g][b];
            assign ycol[b][g] = slot_y[g][b];
        end
    end

    // Lowest-index priority encoders for allocation and detonation.
    assign alloc_vec  = is_free & (~is_free + NUM_BOMBS'(1));
    assign sel_vec    = is_pend & (~is_pend + NUM_BOMBS'(1));
    assign pend_found = |is_pend;

    for (genvar b = 0; b < COORD_W; b++) begin : g_sel
        assign sel_x[b] = |(xcol[b] & sel_vec);
        assign sel_y[b] = |(ycol[b] & sel_vec);
    end

    // A slot frees only after its select edge, so it never looks FREE to the same-cycle request.
    assign accept       = reset && bombRequested && (|is_free) && !(|match);
    assign bombAccepted = accept;

    // Square (Chebyshev) blast test against the player position in the select cycle.
    assign hit = pend_found
              && (absdiff(sel_x, playerX) <= RAD_W'(BLAST_RADIUS))
              && (absdiff(sel_y, playerY) <= RAD_W'(BLAST_RADIUS));

`ifdef STUN_IMMUNITY_EN
    logic [CNT_W-1:0] imm_cnt;
    logic [CNT_W-1:0] imm_nxt;
    assign load_ok = hit_q && (imm_cnt == '0);
`else
    assign load_ok = hit_q;
`endif

    // Stun countdown: a hit reloads (and beats a same-cycle tick), otherwise count down on tick.
    always_comb begin
        stun_nxt = stun_cnt;
`ifdef STUN_IMMUNITY_EN
        imm_nxt = imm_cnt;
        if (tick && (imm_cnt != '0)) begin
            imm_nxt = imm_cnt - CNT_W'(1);
        end
`endif
        if (load_ok) begin
            stun_nxt = CNT_W'(STUN_TICKS);
        end else if (tick && (stun_cnt != '0)) begin
            stun_nxt = stun_cnt - CNT_W'(1);
`ifdef STUN_IMMUNITY_EN
            if (stun_cnt == CNT_W'(1)) begin
                imm_nxt = CNT_W'(IMMUNE_TICKS);
            end
`endif
        end
    end

`ifdef STUN_IMMUNITY_EN
    // Immunity window register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            imm_cnt <= '0;
        end else begin
            imm_cnt <= imm_nxt;
        end
    end
`endif

    // Registered explosion, hit, occupancy and stun outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            explosionValid <= 1'b0;
            explosionX     <= '0;
            explosionY     <= '0;
            hit_q          <= 1'b0;
            activeBombs    <= '0;
            stun_cnt       <= '0;
            stunnedEffect  <= 1'b0;
        end else begin
            explosionValid <= pend_found;
            explosionX     <= sel_x;
            explosionY     <= sel_y;
            hit_q          <= hit;
            activeBombs    <= activeBombs + ACT_W'(accept) - ACT_W'(pend_found);
            stun_cnt       <= stun_nxt;
            stunnedEffect  <= (stun_nxt != '0);
        end
    end

endmodule

// File: tb/tb_stun_detector.sv
// Self-checking bench for stun_detector: directed scenarios plus random traffic against a bomb-list model.
module tb_stun_detector;

    localparam int NB   = 4;
    localparam int FUSE = 8;
    localparam int STUN = 6;
    localparam int RAD  = 2;
    localparam int IMM  = 4;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       bombRequested;
    logic [5:0] bombX;
    logic [5:0] bombY;
    logic [5:0] playerX;
    logic [5:0] playerY;
    logic       bombAccepted;
    logic       explosionValid;
    logic [5:0] explosionX;
    logic [5:0] explosionY;
    logic [3:0] activeBombs;
    logic       stunnedEffect;

    stun_detector dut (
        .clock         (clock),
        .reset         (reset),
        .tick          (tick),
        .bombRequested (bombRequested),
        .bombX         (bombX),
        .bombY         (bombY),
        .playerX       (playerX),
        .playerY       (playerY),
        .bombAccepted  (bombAccepted),
        .explosionValid(explosionValid),
        .explosionX    (explosionX),
        .explosionY    (explosionY),
        .activeBombs   (activeBombs),
        .stunnedEffect (stunnedEffect)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: list of bombs by slot; fuse 0 on a used entry means waiting to detonate.
    bit m_used [NB];
    int m_x    [NB];
    int m_y    [NB];
    int m_fuse [NB];
    bit m_valid;
    int m_ex;
    int m_ey;
    bit m_hit;
    int m_active;
    int m_stun;
    int m_imm;
    logic last_acc;

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic int model_free();
        for (int i = 0; i < NB; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    function automatic bit model_accept();
        if (!reset || !bombRequested || model_free() < 0) return 1'b0;
        for (int i = 0; i < NB; i++)
            if (m_used[i] && m_x[i] == int'(bombX) && m_y[i] == int'(bombY)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        int sel;
        int fr;
        bit acc;
        int imm_old;
        if (!reset) begin
            for (int i = 0; i < NB; i++) m_used[i] = 1'b0;
            m_valid = 0; m_ex = 0; m_ey = 0; m_hit = 0;
            m_active = 0; m_stun = 0; m_imm = 0;
            return;
        end
        acc = model_accept();
        fr  = model_free();
        sel = -1;
        for (int i = 0; i < NB; i++) if (sel < 0 && m_used[i] && m_fuse[i] == 0) sel = i;
        imm_old = m_imm;
        if (tick && m_imm > 0) m_imm--;
        if (m_hit && imm_old == 0) begin
            m_stun = STUN;
        end else if (tick && m_stun > 0) begin
            m_stun--;
`ifdef STUN_IMMUNITY_EN
            if (m_stun == 0) m_imm = IMM;
`endif
        end
        m_valid = (sel >= 0);
        m_ex    = m_valid ? m_x[sel] : 0;
        m_ey    = m_valid ? m_y[sel] : 0;
        m_hit   = m_valid && absd(m_ex, int'(playerX)) <= RAD && absd(m_ey, int'(playerY)) <= RAD;
        for (int i = 0; i < NB; i++) if (m_used[i] && m_fuse[i] > 0 && tick) m_fuse[i]--;
        if (sel >= 0) m_used[sel] = 1'b0;
        if (acc) begin
            m_used[fr] = 1'b1; m_fuse[fr] = FUSE; m_x[fr] = int'(bombX); m_y[fr] = int'(bombY);
        end
        m_active = 0;
        for (int i = 0; i < NB; i++) if (m_used[i]) m_active++;
    endtask

    // One clock: drive inputs, check the combinational accept, advance, check registered outputs.
    task automatic step(input bit r, input bit t, input bit q, input int bx, input int by,
                        input int px, input int py);
        reset = r; tick = t; bombRequested = q;
        bombX = 6'(bx); bombY = 6'(by); playerX = 6'(px); playerY = 6'(py);
        #1;
        last_acc = bombAccepted;
        check("accept", 32'(bombAccepted), 32'(model_accept()));
        model_edge();
        @(posedge clock);
        #1;
        check("valid", 32'(explosionValid), 32'(m_valid));
        if (m_valid) begin
            check("expl_x", 32'(explosionX), 32'(m_ex));
            check("expl_y", 32'(explosionY), 32'(m_ey));
        end
        check("active", 32'(activeBombs), 32'(m_active));
        check("stunned", 32'(stunnedEffect), 32'(m_stun != 0));
    endtask

    task automatic idle(input bit t, input int px, input int py);
        step(1'b1, t, 1'b0, 0, 0, px, py);
    endtask

    function automatic int rc();
        return ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(59, 63));
    endfunction

    initial begin
        int lat;
        int cnt;
        int mx;
        bit found;
        int px;
        int py;

        reset = 1'b0; tick = 1'b0; bombRequested = 1'b0;
        bombX = '0; bombY = '0; playerX = '0; playerY = '0;
        for (int i = 0; i < NB; i++) begin m_used[i] = 0; m_x[i] = 0; m_y[i] = 0; m_fuse[i] = 0; end
        m_valid = 0; m_ex = 0; m_ey = 0; m_hit = 0; m_active = 0; m_stun = 0; m_imm = 0;
        @(posedge clock);
        #1;
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        check("rst_valid", 32'(explosionValid), 0);
        check("rst_active", 32'(activeBombs), 0);
        check("rst_stun", 32'(stunnedEffect), 0);

        // Hit at (10,10) vs player (11,12): latency and stun length.
        step(1'b1, 1'b1, 1'b1, 10, 10, 11, 12);
        check("t1_acc", 32'(last_acc), 1);
        lat = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            idle(1'b1, 11, 12);
            if (explosionValid) begin found = 1; lat = k; end
        end
        check("t1_latency", 32'(lat), 9);
        check("t1_x", 32'(explosionX), 10);
        idle(1'b1, 11, 12);
        check("t1_stun_on", 32'(stunnedEffect), 1);
        cnt = 1;
        for (int k = 0; k < 10; k++) begin idle(1'b1, 11, 12); cnt += int'(stunnedEffect); end
        check("t1_stun_len", 32'(cnt), 6);

        // Miss: |dx| = 3.
        step(1'b0, 1'b1, 1'b0, 0, 0, 13, 10);
        step(1'b1, 1'b1, 1'b1, 10, 10, 13, 10);
        found = 0; mx = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1'b1, 13, 10);
            if (explosionValid) found = 1;
            if (stunnedEffect) mx = 1;
        end
        check("t2_expl", 32'(found), 1);
        check("t2_nostun", 32'(mx), 0);

        // Full slots and duplicate placement.
        step(1'b0, 1'b0, 1'b0, 0, 0, 40, 40);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b1, k, k, 40, 40);
        step(1'b1, 1'b0, 1'b1, 5, 5, 40, 40);
        check("t3_fifth", 32'(last_acc), 0);
        check("t3_active4", 32'(activeBombs), 4);
        step(1'b0, 1'b0, 1'b0, 0, 0, 40, 40);
        step(1'b1, 1'b0, 1'b1, 10, 10, 40, 40);
        step(1'b1, 1'b0, 1'b1, 10, 10, 40, 40);
        check("t3_dup", 32'(last_acc), 0);
        check("t3_active1", 32'(activeBombs), 1);

        // Two bombs expiring on one tick detonate on consecutive cycles, lower slot first.
        step(1'b0, 1'b0, 1'b0, 0, 0, 40, 40);
        step(1'b1, 1'b0, 1'b1, 5, 5, 40, 40);
        step(1'b1, 1'b0, 1'b1, 20, 20, 40, 40);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            idle(1'b1, 40, 40);
            if (explosionValid) found = 1;
        end
        check("t4_found", 32'(found), 1);
        check("t4_first_x", 32'(explosionX), 5);
        idle(1'b1, 40, 40);
        check("t4_second_v", 32'(explosionValid), 1);
        check("t4_second_x", 32'(explosionX), 20);

        // Second hit while stunned reloads the counter.
        step(1'b0, 1'b1, 1'b0, 0, 0, 30, 30);
        step(1'b1, 1'b1, 1'b1, 30, 30, 30, 30);
        cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) step(1'b1, 1'b1, 1'b1, 31, 30, 30, 30);
            else idle(1'b1, 30, 30);
            cnt += int'(stunnedEffect);
        end
        check("t5_reload_len", 32'(cnt), 9);

        // Hit arriving shortly after a stun ends: blocked by immunity when enabled.
        step(1'b0, 1'b1, 1'b0, 0, 0, 30, 30);
        step(1'b1, 1'b1, 1'b1, 30, 30, 30, 30);
        cnt = 0;
        for (int k = 1; k <= 35; k++) begin
            if (k == 9) step(1'b1, 1'b1, 1'b1, 31, 30, 30, 30);
            else idle(1'b1, 30, 30);
            cnt += int'(stunnedEffect);
        end
`ifdef STUN_IMMUNITY_EN
        check("t5_immune_len", 32'(cnt), 6);
`else
        check("t5_no_immune_len", 32'(cnt), 12);
`endif

        // Reset mid-operation: three armed bombs and an active stun.
        step(1'b0, 1'b1, 1'b0, 0, 0, 20, 20);
        step(1'b1, 1'b1, 1'b1, 20, 20, 20, 20);
        for (int k = 0; k < 10; k++) idle(1'b1, 20, 20);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, 1'b1, k, k, 20, 20);
        check("t6_pre_stun", 32'(stunnedEffect), 1);
        check("t6_pre_active", 32'(activeBombs), 3);
        step(1'b0, 1'b1, 1'b0, 0, 0, 20, 20);
        check("t6_valid0", 32'(explosionValid), 0);
        check("t6_active0", 32'(activeBombs), 0);
        check("t6_stun0", 32'(stunnedEffect), 0);
        check("t6_xy0", 32'({explosionX, explosionY}), 0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin idle(1'b1, 20, 20); cnt += int'(explosionValid); end
        check("t6_no_expl", 32'(cnt), 0);

        // Random traffic, including map edges, duplicates and occasional resets.
        px = 2; py = 2;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin px = rc(); py = rc(); end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) != 0),
                 ($urandom_range(0, 2) == 0), rc(), rc(), px, py);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
